mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Shares the single RAM port between the CPU microcode datapath and an external loader/debug requester (UART bootloader, memory inspector). While the CPU owns the port, its RAM control strobes pass straight through. A loader request stalls the CPU at the next instruction boundary, then runs fixed three-cycle RAM transactions. A burst limit and a CPU quantum keep a long load from starving the CPU indefinitely.

## Interface
- `ADDR_W`, 8: RAM address width.
- `MAX_BURST`, 16: loader transactions per grant before forced release. 0 means unlimited.
- `CPU_QUANTUM`, 8: minimum clock cycles the CPU owns the port after a forced release. Must be ≥1.
- `i_clk` in 1: single clock. All state changes on its rising edge.
- `i_nReset` in 1: reset, asynchronous assert, active-low.
- `i_cpuStepZero` in 1: high while the control step counter is 0 (instruction boundary).
- `i_cpuAddrEn`, `i_cpuWriteEn`, `i_cpuOE`, `i_cpuSelect` in 1 each: CPU RAM control strobes.
- `i_cpuAddr` in ADDR_W, `i_cpuWData` in 8: CPU address and write data.
- `o_cpuRData` out 8: read data to the CPU.
- `o_cpuStall` out 1: freezes the CPU step counter.
- `i_ldReq` in 1: loader request. Held high for the whole burst.
- `i_ldWrite` in 1: 1 means write, 0 means read.
- `i_ldSelect` in 1: RAM select (instruction or data RAM).
- `i_ldAddr` in ADDR_W, `i_ldWData` in 8: loader address and write data.
- `o_ldGnt` out 1: loader owns the port.
- `o_ldAck` out 1: one-cycle pulse when a transaction completes.
- `o_ldRData` out 8: registered read data. Valid with `o_ldAck`.
- `o_ramAddrEn`, `o_ramWriteEn`, `o_ramOE`, `o_ramSelect` out 1 each: RAM strobes.
- `o_ramAddr` out ADDR_W, `o_ramWData` out 8: RAM address and write data.
- `i_ramRData` in 8: RAM read data.

## Operation
- **States:** CPU, DRAIN, GRANT, ADDR, DATA, ACK, QUANT.
- **CPU:** RAM outputs are combinational copies of the CPU inputs, and `o_cpuRData` = `i_ramRData`.
  - `i_ldReq` high → DRAIN.
- **DRAIN:** `o_cpuStall` = 1. The CPU strobes still pass through so the current step completes.
  - `i_cpuStepZero` high → GRANT.
  - `i_ldReq` low → CPU.
- **GRANT:** `o_ldGnt` = 1. All RAM strobes are 0.
  - `i_ldReq` high → ADDR. Capture addr, wdata, write and select into registers.
  - `i_ldReq` low → CPU.
- **ADDR:** `o_ramAddrEn` = 1 with the captured address.
- **DATA:** `o_ramWriteEn` = captured write, or `o_ramOE` = ~write. On a read, capture `i_ramRData` into `o_ldRData`.
- **ACK:** `o_ldAck` = 1. Increment the burst counter.
  - Count == MAX_BURST (MAX_BURST ≠ 0) → QUANT: clear the counter, load the quantum counter with CPU_QUANTUM.
  - Otherwise → GRANT.
- **QUANT:** CPU pass-through, `o_cpuStall` = 0, `o_ldGnt` = 0. Decrement the quantum counter each cycle.
  - Reaching 0 → CPU, or DRAIN if `i_ldReq` is high.
- **Stall and grant:** `o_cpuStall` = 1 in DRAIN, GRANT, ADDR, DATA and ACK. `o_ldGnt` = 1 in GRANT, ADDR, DATA and ACK.
- **Burst counter:**
  - Clears on leaving GRANT → CPU.
  - Saturates; it never wraps.
  - Width is $clog2(MAX_BURST+1), minimum 1.
- **Dropping `i_ldReq` mid-transaction:** the transaction completes through ACK; GRANT then releases.

## Timing
- **Reset values:**
  - State: CPU.
  - Counters: 0.
  - Registered outputs (`o_ldGnt`, `o_ldAck`, `o_cpuStall`, `o_ldRData`): 0.
  - While `i_nReset` is low, RAM strobes are forced to 0 regardless of CPU inputs. No write is issued during reset.
- **Reset mid-transaction:** aborts immediately, with no ack.
- **Request to grant:** `i_ldReq` in CPU → `o_cpuStall` the next cycle. `o_ldGnt` comes one cycle after `i_cpuStepZero` is seen in DRAIN.
  - Minimum 2 cycles when already at step 0.
- **Transaction:** 3 cycles, GRANT→ADDR→DATA→ACK.
  - Back-to-back transactions: one every 4 cycles, including the GRANT cycle.
- **Read data:** `o_ldRData` is stable from ACK until the next DATA cycle.
- **Simultaneous events:**
  - `i_ldReq` high in the last QUANT cycle goes directly to DRAIN.
  - During QUANT, CPU accesses always win.

## Structure
- **Shared package `edic_pkg`:** the `mem_arb_state_t` enum (7 states) and a `RAM_DATA_W` = 8 constant.
- **Sub-modules:** none. Flat FSM plus two counters and the capture registers.

## Test plan
- **Reset:** `i_nReset` low with CPU `i_cpuWriteEn`=1 → all RAM strobes 0, `o_cpuStall`=0, `o_ldGnt`=0.
- **CPU pass-through:** CPU owns the port, `i_cpuAddr`=0x3C, `i_cpuWriteEn`=1 → `o_ramAddr`=0x3C and `o_ramWriteEn`=1 in the same cycle.
- **Drain wait:** `i_ldReq` raised at step 2 → `o_cpuStall`=1 next cycle. `o_ldGnt` rises one cycle after `i_cpuStepZero`, not before.
- **Loader write:** write 0xA5 to addr 0x10.
  - ADDR cycle: `o_ramAddrEn`=1, `o_ramAddr`=0x10.
  - DATA cycle: `o_ramWriteEn`=1, `o_ramWData`=0xA5.
  - ACK cycle: `o_ldAck`=1.
- **Loader read:** read addr 0x10 with RAM model returning 0xA5 → `o_ldRData`=0xA5 with `o_ldAck`.
- **Forced release:** MAX_BURST=2, `i_ldReq` held high → 2 acks, then `o_ldGnt`=0 and `o_cpuStall`=0 for exactly 8 cycles, then DRAIN again.

Source files
------------

// File: rtl/edic_pkg.sv
// Shared types for the RAM port arbiter: FSM state encoding and RAM data width.
package edic_pkg;

    localparam int RAM_DATA_W = 8;

    typedef enum logic [2:0] {
        ST_CPU,
        ST_DRAIN,
        ST_GRANT,
        ST_ADDR,
        ST_DATA,
        ST_ACK,
        ST_QUANT
    } mem_arb_state_t;

    function automatic logic stallIn(input mem_arb_state_t s);
        return s inside {ST_DRAIN, ST_GRANT, ST_ADDR, ST_DATA, ST_ACK};
    endfunction

    function automatic logic gntIn(input mem_arb_state_t s);
        return s inside {ST_GRANT, ST_ADDR, ST_DATA, ST_ACK};
    endfunction

endpackage

// File: rtl/mem_arbiter.sv
// Shares one RAM port between the CPU datapath and a loader/debug requester,
// with a burst limit and a guaranteed CPU quantum after a forced release.
module mem_arbiter
    import edic_pkg::*;
#(
    parameter int ADDR_W      = 8,
    parameter int MAX_BURST   = 16,
    parameter int CPU_QUANTUM = 8
) (
    input  logic                  i_clk,
    input  logic                  i_nReset,
    input  logic                  i_cpuStepZero,
    input  logic                  i_cpuAddrEn,
    input  logic                  i_cpuWriteEn,
    input  logic                  i_cpuOE,
    input  logic                  i_cpuSelect,
    input  logic [ADDR_W-1:0]     i_cpuAddr,
    input  logic [RAM_DATA_W-1:0] i_cpuWData,
    output logic [RAM_DATA_W-1:0] o_cpuRData,
    output logic                  o_cpuStall,
    input  logic                  i_ldReq,
    input  logic                  i_ldWrite,
    input  logic                  i_ldSelect,
    input  logic [ADDR_W-1:0]     i_ldAddr,
    input  logic [RAM_DATA_W-1:0] i_ldWData,
    output logic                  o_ldGnt,
    output logic                  o_ldAck,
    output logic [RAM_DATA_W-1:0] o_ldRData,
    output logic                  o_ramAddrEn,
    output logic                  o_ramWriteEn,
    output logic                  o_ramOE,
    output logic                  o_ramSelect,
    output logic [ADDR_W-1:0]     o_ramAddr,
    output logic [RAM_DATA_W-1:0] o_ramWData,
    input  logic [RAM_DATA_W-1:0] i_ramRData,
    output mem_arb_state_t        o_dbgState
);

    localparam int BURST_W = (MAX_BURST < 1) ? 1 : $clog2(MAX_BURST + 1);
    localparam int QUANT_W = (CPU_QUANTUM < 1) ? 1 : $clog2(CPU_QUANTUM + 1);

    // Loader handshake: i_ldReq held high means the ld* fields are valid; they are
    // taken in the GRANT cycle, o_ldAck marks completion, and new fields may be
    // presented from the ack cycle onward for the next transaction.
    mem_arb_state_t        state, nextState;
    logic [BURST_W-1:0]    burstCnt, burstNext;
    logic [QUANT_W-1:0]    quantCnt;
    logic                  burstLimit;
    logic [ADDR_W-1:0]     capAddr;
    logic [RAM_DATA_W-1:0] capWData;
    logic                  capWrite;
    logic                  capSelect;

    always_comb begin
        burstNext  = (burstCnt == '1) ? burstCnt : burstCnt + BURST_W'(1);
        burstLimit = (MAX_BURST != 0) && (burstNext == BURST_W'(MAX_BURST));
    end

    always_comb begin
        nextState = state;
        case (state)
            ST_CPU:   if (i_ldReq) nextState = ST_DRAIN;
            ST_DRAIN: if (!i_ldReq) nextState = ST_CPU;
                      else if (i_cpuStepZero) nextState = ST_GRANT;
            ST_GRANT: nextState = i_ldReq ? ST_ADDR : ST_CPU;
            ST_ADDR:  nextState = ST_DATA;
            ST_DATA:  nextState = ST_ACK;
            ST_ACK:   nextState = burstLimit ? ST_QUANT : ST_GRANT;
            ST_QUANT: if (quantCnt <= QUANT_W'(1)) nextState = i_ldReq ? ST_DRAIN : ST_CPU;
            default:  nextState = ST_CPU;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_nReset) begin
        if (!i_nReset) begin
            state      <= ST_CPU;
            burstCnt   <= '0;
            quantCnt   <= '0;
            o_cpuStall <= 1'b0;
            o_ldGnt    <= 1'b0;
            o_ldAck    <= 1'b0;
            o_ldRData  <= '0;
            capAddr    <= '0;
            capWData   <= '0;
            capWrite   <= 1'b0;
            capSelect  <= 1'b0;
        end else begin
            state      <= nextState;
            o_cpuStall <= stallIn(nextState);
            o_ldGnt    <= gntIn(nextState);
            o_ldAck    <= (nextState == ST_ACK);
            case (state)
                ST_GRANT: begin
                    if (i_ldReq) begin
                        capAddr   <= i_ldAddr;
                        capWData  <= i_ldWData;
                        capWrite  <= i_ldWrite;
                        capSelect <= i_ldSelect;
                    end else begin
                        burstCnt  <= '0;
                    end
                end
                ST_DATA: if (!capWrite) o_ldRData <= i_ramRData;
                ST_ACK: begin
                    if (burstLimit) begin
                        burstCnt <= '0;
                        quantCnt <= QUANT_W'(CPU_QUANTUM);
                    end else begin
                        burstCnt <= burstNext;
                    end
                end
                ST_QUANT: if (quantCnt != '0) quantCnt <= quantCnt - QUANT_W'(1);
                default: ;
            endcase
        end
    end

    // RAM strobes are gated by reset directly so nothing reaches the RAM while held in reset.
    always_comb begin
        o_ramAddrEn  = 1'b0;
        o_ramWriteEn = 1'b0;
        o_ramOE      = 1'b0;
        o_ramSelect  = 1'b0;
        o_ramAddr    = '0;
        o_ramWData   = '0;
        if (i_nReset) begin
            case (state)
                ST_CPU, ST_DRAIN, ST_QUANT: begin
                    o_ramAddrEn  = i_cpuAddrEn;
                    o_ramWriteEn = i_cpuWriteEn;
                    o_ramOE      = i_cpuOE;
                    o_ramSelect  = i_cpuSelect;
                    o_ramAddr    = i_cpuAddr;
                    o_ramWData   = i_cpuWData;
                end
                ST_ADDR: begin
                    o_ramAddrEn  = 1'b1;
                    o_ramSelect  = capSelect;
                    o_ramAddr    = capAddr;
                    o_ramWData   = capWData;
                end
                ST_DATA: begin
                    o_ramWriteEn = capWrite;
                    o_ramOE      = ~capWrite;
                    o_ramSelect  = capSelect;
                    o_ramAddr    = capAddr;
                    o_ramWData   = capWData;
                end
                default: ;
            endcase
        end
    end

    assign o_cpuRData = i_ramRData;
    assign o_dbgState = state;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed and randomized checks of mem_arbiter against a RAM model and a
// shadow-memory / ack-spacing reference derived from the arbitration rules.
module tb_mem_arbiter;
    import edic_pkg::*;

    localparam int MB = 2;
    localparam int QU = 8;

    logic       i_clk = 1'b0;
    logic       i_nReset;
    logic       i_cpuStepZero, i_cpuAddrEn, i_cpuWriteEn, i_cpuOE, i_cpuSelect;
    logic [7:0] i_cpuAddr, i_cpuWData, o_cpuRData;
    logic       o_cpuStall;
    logic       i_ldReq, i_ldWrite, i_ldSelect;
    logic [7:0] i_ldAddr, i_ldWData, o_ldRData;
    logic       o_ldGnt, o_ldAck;
    logic       o_ramAddrEn, o_ramWriteEn, o_ramOE, o_ramSelect;
    logic [7:0] o_ramAddr, o_ramWData, i_ramRData;
    mem_arb_state_t o_dbgState;

    int nChecks = 0;
    int nFails  = 0;

    logic [7:0] ram [2][256];
    logic [7:0] shadow [bit [8:0]];
    bit   [8:0] wlist [$];
    logic [7:0] exp_q [$];

    int         nTr, cyc, free, expGap;
    logic       ok, curWr;
    bit   [8:0] key;
    logic [7:0] curData;

    always #5 i_clk = ~i_clk;

    mem_arbiter #(.ADDR_W(8), .MAX_BURST(MB), .CPU_QUANTUM(QU)) dut (
        .i_clk(i_clk), .i_nReset(i_nReset), .i_cpuStepZero(i_cpuStepZero),
        .i_cpuAddrEn(i_cpuAddrEn), .i_cpuWriteEn(i_cpuWriteEn), .i_cpuOE(i_cpuOE),
        .i_cpuSelect(i_cpuSelect), .i_cpuAddr(i_cpuAddr), .i_cpuWData(i_cpuWData),
        .o_cpuRData(o_cpuRData), .o_cpuStall(o_cpuStall), .i_ldReq(i_ldReq),
        .i_ldWrite(i_ldWrite), .i_ldSelect(i_ldSelect), .i_ldAddr(i_ldAddr),
        .i_ldWData(i_ldWData), .o_ldGnt(o_ldGnt), .o_ldAck(o_ldAck), .o_ldRData(o_ldRData),
        .o_ramAddrEn(o_ramAddrEn), .o_ramWriteEn(o_ramWriteEn), .o_ramOE(o_ramOE),
        .o_ramSelect(o_ramSelect), .o_ramAddr(o_ramAddr), .o_ramWData(o_ramWData),
        .i_ramRData(i_ramRData), .o_dbgState(o_dbgState)
    );

    // RAM model: synchronous write, combinational read.
    always @(posedge i_clk) if (o_ramWriteEn) ram[o_ramSelect][o_ramAddr] <= o_ramWData;
    assign i_ramRData = ram[o_ramSelect][o_ramAddr];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nChecks++;
        assert (obs === exp) else begin
            nFails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_ack(output int c, output int f, output logic got);
        c = 0; f = 0; got = 1'b0;
        for (int k = 0; k < 40 && !got; k++) begin
            @(negedge i_clk);
            c++;
            if (!o_ldGnt && !o_cpuStall) f++;
            if (o_ldAck) got = 1'b1;
        end
    endtask

    task automatic set_ld(input logic wr, input logic sel, input logic [7:0] addr, input logic [7:0] data);
        i_ldWrite  = wr;
        i_ldSelect = sel;
        i_ldAddr   = addr;
        i_ldWData  = data;
    endtask

    task automatic note_write(input bit [8:0] k, input logic [7:0] d);
        if (!shadow.exists(k)) wlist.push_back(k);
        shadow[k] = d;
    endtask

    initial begin
        i_nReset = 1'b1; i_cpuStepZero = 1'b0; i_cpuAddrEn = 1'b0; i_cpuWriteEn = 1'b0;
        i_cpuOE = 1'b0; i_cpuSelect = 1'b0; i_cpuAddr = '0; i_cpuWData = '0;
        i_ldReq = 1'b0; set_ld(1'b0, 1'b0, 8'h00, 8'h00);

        // Reset with CPU strobes active
        #3 i_nReset = 1'b0;
        i_cpuWriteEn = 1'b1; i_cpuAddrEn = 1'b1; i_cpuOE = 1'b1; i_cpuSelect = 1'b1; i_cpuAddr = 8'h55;
        repeat (2) @(negedge i_clk);
        check("rst_writeEn", o_ramWriteEn, 0);
        check("rst_addrEn", o_ramAddrEn, 0);
        check("rst_oe", o_ramOE, 0);
        check("rst_select", o_ramSelect, 0);
        check("rst_stall", o_cpuStall, 0);
        check("rst_gnt", o_ldGnt, 0);
        check("rst_ack", o_ldAck, 0);
        check("rst_rdata", o_ldRData, 0);
        check("rst_state", o_dbgState, ST_CPU);
        i_cpuWriteEn = 1'b0; i_cpuAddrEn = 1'b0; i_cpuOE = 1'b0; i_cpuSelect = 1'b0;
        i_nReset = 1'b1;
        @(negedge i_clk);

        // CPU pass-through write
        i_cpuAddr = 8'h3C; i_cpuWData = 8'h77; i_cpuWriteEn = 1'b1; i_cpuAddrEn = 1'b1;
        #1;
        check("pt_addr", o_ramAddr, 8'h3C);
        check("pt_writeEn", o_ramWriteEn, 1);
        check("pt_wdata", o_ramWData, 8'h77);
        check("pt_stall", o_cpuStall, 0);
        @(negedge i_clk);
        i_cpuWriteEn = 1'b0; i_cpuAddrEn = 1'b0;
        note_write(9'h03C, 8'h77);
        #1 check("pt_rdata", o_cpuRData, 8'h77);

        // Drain wait: request away from an instruction boundary
        i_cpuStepZero = 1'b0;
        set_ld(1'b1, 1'b0, 8'h10, 8'hA5);
        i_ldReq = 1'b1;
        @(negedge i_clk);
        check("drain_stall", o_cpuStall, 1);
        check("drain_gnt0", o_ldGnt, 0);
        @(negedge i_clk);
        check("drain_gnt1", o_ldGnt, 0);
        i_cpuStepZero = 1'b1;
        @(negedge i_clk);
        check("grant_gnt", o_ldGnt, 1);
        i_cpuWriteEn = 1'b1;
        #1 check("grant_cpu_blocked", o_ramWriteEn, 0);
        i_cpuWriteEn = 1'b0;

        // Loader write 0xA5 -> 0x10
        @(negedge i_clk);
        check("wr_addrEn", o_ramAddrEn, 1);
        check("wr_addr", o_ramAddr, 8'h10);
        check("wr_addr_noWe", o_ramWriteEn, 0);
        @(negedge i_clk);
        check("wr_writeEn", o_ramWriteEn, 1);
        check("wr_wdata", o_ramWData, 8'hA5);
        check("wr_oe", o_ramOE, 0);
        @(negedge i_clk);
        check("wr_ack", o_ldAck, 1);
        note_write(9'h010, 8'hA5);

        // Loader read of 0x10, second transaction of the grant
        set_ld(1'b0, 1'b0, 8'h10, 8'h00);
        @(negedge i_clk);
        check("rd_grant_noack", o_ldAck, 0);
        check("rd_grant_gnt", o_ldGnt, 1);
        @(negedge i_clk);
        @(negedge i_clk);
        check("rd_oe", o_ramOE, 1);
        check("rd_noWe", o_ramWriteEn, 0);
        @(negedge i_clk);
        check("rd_ack", o_ldAck, 1);
        check("rd_rdata", o_ldRData, 8'hA5);

        // Forced release after MB transactions with request still high
        i_cpuAddr = 8'h3C; i_cpuOE = 1'b1;
        free = 0;
        for (int k = 0; k < QU; k++) begin
            @(negedge i_clk);
            if (!o_ldGnt && !o_cpuStall) free++;
            if (k == 0) begin
                check("quant_pt_addr", o_ramAddr, 8'h3C);
                check("quant_pt_oe", o_ramOE, 1);
            end
        end
        check("quant_free_cycles", free, QU);
        i_cpuOE = 1'b0;
        @(negedge i_clk);
        check("redrain_stall", o_cpuStall, 1);
        check("redrain_gnt", o_ldGnt, 0);
        @(negedge i_clk);
        check("regrant_gnt", o_ldGnt, 1);
        i_ldReq = 1'b0;
        @(negedge i_clk);
        check("release_gnt", o_ldGnt, 0);
        check("release_stall", o_cpuStall, 0);

        // Request dropped mid-transaction: completes, then releases
        set_ld(1'b1, 1'b1, 8'h20, 8'h5A);
        i_ldReq = 1'b1;
        repeat (3) @(negedge i_clk);
        i_ldReq = 1'b0;
        @(negedge i_clk);
        check("drop_writeEn", o_ramWriteEn, 1);
        @(negedge i_clk);
        check("drop_ack", o_ldAck, 1);
        note_write(9'h120, 8'h5A);
        @(negedge i_clk);
        check("drop_grant_gnt", o_ldGnt, 1);
        @(negedge i_clk);
        check("drop_release_gnt", o_ldGnt, 0);
        check("drop_release_stall", o_cpuStall, 0);

        // Reset in the DATA cycle of a write aborts it
        set_ld(1'b1, 1'b0, 8'h30, 8'hFF);
        i_ldReq = 1'b1;
        repeat (4) @(negedge i_clk);
        check("abort_pre_we", o_ramWriteEn, 1);
        i_nReset = 1'b0;
        #1;
        check("abort_we", o_ramWriteEn, 0);
        check("abort_gnt", o_ldGnt, 0);
        check("abort_stall", o_cpuStall, 0);
        i_ldReq = 1'b0;
        repeat (2) @(negedge i_clk);
        check("abort_noack", o_ldAck, 0);
        i_nReset = 1'b1;
        @(negedge i_clk);
        check("abort_state", o_dbgState, ST_CPU);

        // Randomized bursts against shadow memory and ack-spacing model
        for (int b = 0; b < 4; b++) begin
            nTr = $urandom_range(3, 6);
            for (int t = 0; t < nTr; t++) begin
                curWr = (wlist.size() == 0) || ($urandom_range(0, 1) == 1);
                if (curWr) begin
                    key = 9'($urandom_range(0, 511));
                    curData = 8'($urandom_range(0, 255));
                end else begin
                    key = wlist[$urandom_range(0, wlist.size() - 1)];
                    curData = 8'h00;
                    exp_q.push_back(shadow[key]);
                end
                set_ld(curWr, key[8], key[7:0], curData);
                if (t == 0) i_ldReq = 1'b1;
                wait_ack(cyc, free, ok);
                check("rnd_ack_seen", ok, 1);
                expGap = (t == 0) ? 5 : (((t % MB) == 0) ? (QU + 5) : 4);
                check("rnd_ack_gap", cyc, expGap);
                check("rnd_free_cycles", free, (expGap == QU + 5) ? QU : 0);
                if (curWr) note_write(key, curData);
                else if (exp_q.size() > 0) check("rnd_rdata", o_ldRData, exp_q.pop_front());
                if (t == nTr - 1) i_ldReq = 1'b0;
            end
            repeat (QU + 4) @(negedge i_clk);
            check("rnd_idle_gnt", o_ldGnt, 0);
            check("rnd_idle_stall", o_cpuStall, 0);
        end
        check("exp_q_empty", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
